// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multicycle control FSM: opcodes, states,
// datapath mux selects and the packed control word driven each cycle.
package multicycle_control_fsm_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned STATE_W_C = 4;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [STATE_W_C-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             adr_src;
        logic             ir_write;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle FSM (master) and the shared datapath (slave).
interface multicycle_control_fsm_if #(
    parameter int unsigned STATE_W = 4
);
    import multicycle_control_fsm_pkg::*;

    logic [OPCODE_W-1:0] op_code;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                adr_src;
    logic                ir_write;
    logic                mem_write;
    logic                reg_write;
    logic [SEL_W-1:0]    result_src;
    logic [SEL_W-1:0]    alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [SEL_W-1:0]    alu_op;
    logic [SEL_W-1:0]    imm_src;
    logic                instr_done;
    logic                illegal_op;
    logic [STATE_W-1:0]  state_dbg;

    modport master (
        input  op_code, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               instr_done, illegal_op, state_dbg
    );

    modport slave (
        output op_code, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               instr_done, illegal_op, state_dbg
    );

endinterface

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// Immediate-format select for the extend unit, decoded straight from the opcode.
module imm_src_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [OPCODE_W-1:0] op_code_i,
    output logic [SEL_W-1:0]    imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_code_i)
            OPC_STORE:  imm_src_o = IMM_S;
            OPC_BRANCH: imm_src_o = IMM_B;
            default:    imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM sequencing the shared RV32I multicycle datapath one step per cycle.
// Control outputs are decoded from the current state plus mem_ready/zero.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned STATE_W  = 4,
    parameter bit          WAIT_MEM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_c;
    logic             instr_done_c;
    logic             illegal_op_c;
    logic             mem_ready_c;
    logic [SEL_W-1:0] imm_src_c;

    assign mem_ready_c = WAIT_MEM ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ctrl_c       = '0;
        instr_done_c = 1'b0;
        illegal_op_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.alu_op     = ALUOP_ADD;
                ctrl_c.result_src = RES_ALURESULT;
                if (mem_ready_c) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                case (bus.op_code)
                    OPC_LOAD,
                    OPC_STORE:  state_d = S_MEMADR;
                    OPC_OP:     state_d = S_EXECR;
                    OPC_OP_IMM: state_d = S_EXECI;
                    OPC_BRANCH: state_d = S_BRANCH;
                    default: begin
                        illegal_op_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                state_d = (bus.op_code == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl_c.adr_src    = 1'b1;
                ctrl_c.result_src = RES_ALUOUT;
                if (mem_ready_c) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl_c.result_src = RES_MEMDATA;
                ctrl_c.reg_write  = 1'b1;
                instr_done_c      = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_c.adr_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                if (mem_ready_c) begin
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXECR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_RS2;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_ALUWB;
            end
            S_EXECI: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
                instr_done_c      = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                // PC loads the target held in ALUOut only when rs1 == rs2.
                ctrl_c.alu_src_a  = SRCA_RS1;
                ctrl_c.alu_src_b  = SRCB_RS2;
                ctrl_c.alu_op     = ALUOP_BRANCH;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = bus.zero;
                instr_done_c      = 1'b1;
                state_d           = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every architectural side effect, even mid-instruction.
        if (rst) begin
            ctrl_c.pc_write  = 1'b0;
            ctrl_c.ir_write  = 1'b0;
            ctrl_c.mem_write = 1'b0;
            ctrl_c.reg_write = 1'b0;
            instr_done_c     = 1'b0;
            illegal_op_c     = 1'b0;
        end
    end

    imm_src_decoder u_imm_src_decoder (
        .op_code_i (bus.op_code),
        .imm_src_o (imm_src_c)
    );

    assign bus.pc_write   = ctrl_c.pc_write;
    assign bus.adr_src    = ctrl_c.adr_src;
    assign bus.ir_write   = ctrl_c.ir_write;
    assign bus.mem_write  = ctrl_c.mem_write;
    assign bus.reg_write  = ctrl_c.reg_write;
    assign bus.result_src = ctrl_c.result_src;
    assign bus.alu_src_a  = ctrl_c.alu_src_a;
    assign bus.alu_src_b  = ctrl_c.alu_src_b;
    assign bus.alu_op     = ctrl_c.alu_op;
    assign bus.imm_src    = imm_src_c;
    assign bus.instr_done = instr_done_c;
    assign bus.illegal_op = illegal_op_c;
    assign bus.state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by
// cycle and compares state plus the full control word against hand-written values.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    // {pc_w, adr, ir_w, mem_w, reg_w}, result_src, src_a, src_b, alu_op, {done, illegal}
    localparam logic [14:0] W_FETCH_STALL = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [14:0] W_FETCH_GO    = {5'b10100, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [14:0] W_DECODE      = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] W_DECODE_ILL  = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    localparam logic [14:0] W_MEMADR      = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] W_MEMREAD     = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_MEMWB       = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [14:0] W_MEMWR_WAIT  = {5'b01010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_MEMWR_GO    = {5'b01010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [14:0] W_EXECR       = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [14:0] W_EXECI       = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [14:0] W_ALUWB       = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [14:0] W_ALUWB_RST   = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_BR_TAKEN    = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    localparam logic [14:0] W_BR_NOT      = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.STATE_W(4)) bus ();

    multicycle_control_fsm #(
        .STATE_W  (4),
        .WAIT_MEM (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [14:0] cw_obs;
    assign cw_obs = {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
                     bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.instr_done, bus.illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, compare state and control word, then advance.
    task automatic cyc(input string tag, input logic [6:0] op, input logic z, input logic mr,
                       input logic [3:0] exp_st, input logic [14:0] exp_cw);
        bus.op_code   = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        #1;
        check({tag, ".state"}, 32'(bus.state_dbg), 32'(exp_st));
        check({tag, ".ctrl"},  32'(cw_obs),        32'(exp_cw));
        @(posedge clk);
        #1;
    endtask

    logic [6:0] imm_ops [6];
    logic [1:0] imm_exp [6];

    initial begin
        rst           = 1'b1;
        bus.op_code   = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset: FETCH, enables forced low even though mem_ready=1
        cyc("rst", OP_LW, 1'b0, 1'b1, ST_FETCH, W_FETCH_STALL);
        rst = 1'b0;

        // Reset asserted while in EXECR
        cyc("t1.fetch",  OP_R, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t1.decode", OP_R, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        rst = 1'b1;
        cyc("t1.execr",  OP_R, 1'b0, 1'b1, ST_EXECR,  W_EXECR);
        cyc("t1.inrst",  OP_R, 1'b0, 1'b1, ST_FETCH,  W_FETCH_STALL);
        rst = 1'b0;

        // lw, no wait states
        cyc("t2.fetch",  OP_LW, 1'b0, 1'b1, ST_FETCH,   W_FETCH_GO);
        cyc("t2.decode", OP_LW, 1'b0, 1'b1, ST_DECODE,  W_DECODE);
        cyc("t2.memadr", OP_LW, 1'b0, 1'b1, ST_MEMADR,  W_MEMADR);
        cyc("t2.memrd",  OP_LW, 1'b0, 1'b1, ST_MEMREAD, W_MEMREAD);
        cyc("t2.memwb",  OP_LW, 1'b0, 1'b1, ST_MEMWB,   W_MEMWB);

        // lw with one wait in MEMREAD
        cyc("t2w.fetch",  OP_LW, 1'b0, 1'b1, ST_FETCH,   W_FETCH_GO);
        cyc("t2w.decode", OP_LW, 1'b0, 1'b1, ST_DECODE,  W_DECODE);
        cyc("t2w.memadr", OP_LW, 1'b0, 1'b1, ST_MEMADR,  W_MEMADR);
        cyc("t2w.wait",   OP_LW, 1'b0, 1'b0, ST_MEMREAD, W_MEMREAD);
        cyc("t2w.memrd",  OP_LW, 1'b0, 1'b1, ST_MEMREAD, W_MEMREAD);
        cyc("t2w.memwb",  OP_LW, 1'b0, 1'b1, ST_MEMWB,   W_MEMWB);

        // sw, three wait cycles in MEMWRITE: 7 cycles total
        cyc("t3.fetch",  OP_SW, 1'b0, 1'b1, ST_FETCH,    W_FETCH_GO);
        cyc("t3.decode", OP_SW, 1'b0, 1'b1, ST_DECODE,   W_DECODE);
        cyc("t3.memadr", OP_SW, 1'b0, 1'b1, ST_MEMADR,   W_MEMADR);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("t3.wait%0d", i), OP_SW, 1'b0, 1'b0, ST_MEMWRITE, W_MEMWR_WAIT);
        end
        cyc("t3.memwr",  OP_SW, 1'b0, 1'b1, ST_MEMWRITE, W_MEMWR_GO);

        // beq taken / not taken
        cyc("t4a.fetch",  OP_BEQ, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t4a.decode", OP_BEQ, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        cyc("t4a.branch", OP_BEQ, 1'b1, 1'b1, ST_BRANCH, W_BR_TAKEN);
        cyc("t4b.fetch",  OP_BEQ, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t4b.decode", OP_BEQ, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        cyc("t4b.branch", OP_BEQ, 1'b0, 1'b1, ST_BRANCH, W_BR_NOT);

        // R-type and I-type ALU ops
        cyc("t5r.fetch",  OP_R, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t5r.decode", OP_R, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        cyc("t5r.exec",   OP_R, 1'b0, 1'b1, ST_EXECR,  W_EXECR);
        cyc("t5r.aluwb",  OP_R, 1'b0, 1'b1, ST_ALUWB,  W_ALUWB);
        cyc("t5i.fetch",  OP_I, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t5i.decode", OP_I, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        cyc("t5i.exec",   OP_I, 1'b0, 1'b1, ST_EXECI,  W_EXECI);
        cyc("t5i.aluwb",  OP_I, 1'b0, 1'b1, ST_ALUWB,  W_ALUWB);

        // Reset in ALUWB must squash reg_write and instr_done
        cyc("t1b.fetch",  OP_R, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t1b.decode", OP_R, 1'b0, 1'b1, ST_DECODE, W_DECODE);
        cyc("t1b.exec",   OP_R, 1'b0, 1'b1, ST_EXECR,  W_EXECR);
        rst = 1'b1;
        cyc("t1b.aluwb",  OP_R, 1'b0, 1'b1, ST_ALUWB,  W_ALUWB_RST);
        cyc("t1b.inrst",  OP_R, 1'b0, 1'b1, ST_FETCH,  W_FETCH_STALL);
        rst = 1'b0;

        // Illegal opcode, then FETCH stalls on mem_ready=0
        cyc("t6.fetch",  OP_JAL, 1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t6.decode", OP_JAL, 1'b0, 1'b1, ST_DECODE, W_DECODE_ILL);
        cyc("t6.stall0", OP_JAL, 1'b0, 1'b0, ST_FETCH,  W_FETCH_STALL);
        cyc("t6.stall1", OP_JAL, 1'b0, 1'b0, ST_FETCH,  W_FETCH_STALL);
        cyc("t6.fetch2", OP_R,   1'b0, 1'b1, ST_FETCH,  W_FETCH_GO);
        cyc("t6.decode2",OP_R,   1'b0, 1'b1, ST_DECODE, W_DECODE);

        // imm_src decode table
        imm_ops[0] = OP_LW;  imm_exp[0] = 2'b00;
        imm_ops[1] = OP_SW;  imm_exp[1] = 2'b01;
        imm_ops[2] = OP_BEQ; imm_exp[2] = 2'b10;
        imm_ops[3] = OP_I;   imm_exp[3] = 2'b00;
        imm_ops[4] = OP_R;   imm_exp[4] = 2'b00;
        imm_ops[5] = OP_JAL; imm_exp[5] = 2'b00;
        for (int i = 0; i < 6; i++) begin
            bus.op_code = imm_ops[i];
            #1;
            check($sformatf("imm_src.%0d", i), 32'(bus.imm_src), 32'(imm_exp[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
